// File: rtl/nexys_io_pkg.sv
// Shared definitions for the Nexys A7 switch/LED path: LED mode encoding,
// 100 MHz timing defaults and a ceiling-log2 helper for counter widths.
package nexys_io_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES  = 1000000;   // 10 ms at 100 MHz
  localparam int DEFAULT_HEARTBEAT_CYCLES = 50000000;  // 0.5 s at 100 MHz

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/switch_debounce_leds_debounce_channel.sv
// One switch channel: metastability chain, stability counter, debounced level
// and registered rise/fall pulses.
module debounce_channel
  import nexys_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic clear,
  input  logic switch_raw,
  output logic sw_stable,
  output logic rise,
  output logic fall,
  output logic rise_set
);

  localparam int              CNT_W    = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync_out;
  logic                   differ;
  logic                   accept;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign differ   = sync_out ^ sw_stable;
  assign accept   = differ && (cnt_q == CNT_LAST);
  // Exported so the top can update toggle/count state on the same edge as rise.
  assign rise_set = accept && !sw_stable;

  always_ff @(posedge clock) begin
    if (clear) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      sw_stable <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], switch_raw};
      if (!differ || accept) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        sw_stable <= ~sw_stable;
      end
      rise <= rise_set;
      fall <= accept && sw_stable;
    end
  end

endmodule

// File: rtl/switch_debounce_leds.sv
// Debounced switch-to-LED block with pass/toggle/count/freeze LED modes.
// Optional heartbeat on the top LED: define SWITCH_DEBOUNCE_LEDS_HEARTBEAT_EN.
module switch_debounce_leds
  import nexys_io_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HEARTBEAT_CYCLES = DEFAULT_HEARTBEAT_CYCLES
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] switches,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] toggle_q;
  logic [WIDTH-1:0] event_q;
  logic [WIDTH-1:0] event_add;
  logic [WIDTH-1:0] leds_q;
  logic [WIDTH-1:0] leds_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clock      (clock),
      .clear      (clear),
      .switch_raw (switches[i]),
      .sw_stable  (sw_stable[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .rise_set   (rise_set[i])
    );
  end

  // Popcount summed at WIDTH bits; the counter wraps modulo 2^WIDTH anyway.
  always_comb begin
    event_add = '0;
    for (int i = 0; i < WIDTH; i++) begin
      event_add = event_add + WIDTH'(rise_set[i]);
    end
  end

  always_comb begin
    leds_d = leds_q;
    case (mode_e'(mode))
      MODE_PASS:   leds_d = sw_stable;
      MODE_TOGGLE: leds_d = toggle_q;
      MODE_COUNT:  leds_d = event_q;
      MODE_FREEZE: leds_d = leds_q;
      default:     leds_d = leds_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      toggle_q <= '0;
      event_q  <= '0;
      leds_q   <= '0;
    end else begin
      toggle_q <= toggle_q ^ rise_set;
      event_q  <= event_q + event_add;
      leds_q   <= leds_d;
    end
  end

`ifdef SWITCH_DEBOUNCE_LEDS_HEARTBEAT_EN
  localparam int               HB_W    = (HEARTBEAT_CYCLES > 1) ? clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

  logic [HB_W-1:0] hb_cnt_q;
  logic            hb_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (hb_cnt_q == HB_LAST) begin
      hb_cnt_q <= '0;
      hb_q     <= ~hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q + 1'b1;
    end
  end

  // Heartbeat owns the top LED in every mode, freeze included.
  always_comb begin
    leds            = leds_q;
    leds[WIDTH-1]   = hb_q;
  end
`else
  logic unused_heartbeat_cfg;
  assign unused_heartbeat_cfg = (HEARTBEAT_CYCLES > 0);
  assign leds = leds_q;
`endif

endmodule

// File: tb/tb_switch_debounce_leds.sv
// Self-checking bench for switch_debounce_leds (WIDTH=4, SYNC=2, DEBOUNCE=4,
// HEARTBEAT=8); honours SWITCH_DEBOUNCE_LEDS_HEARTBEAT_EN when defined.
module tb_switch_debounce_leds;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;
  localparam int H = 8;

`ifdef SWITCH_DEBOUNCE_LEDS_HEARTBEAT_EN
  localparam logic [3:0] LMASK = 4'b0111;
`else
  localparam logic [3:0] LMASK = 4'b1111;
`endif

  logic         clock = 1'b0;
  logic         clear;
  logic [W-1:0] switches;
  logic [1:0]   mode;
  logic [W-1:0] leds;
  logic [W-1:0] sw_stable;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  switch_debounce_leds #(
    .WIDTH            (W),
    .SYNC_STAGES      (S),
    .DEBOUNCE_CYCLES  (D),
    .HEARTBEAT_CYCLES (H)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .switches  (switches),
    .mode      (mode),
    .leds      (leds),
    .sw_stable (sw_stable),
    .rise      (rise),
    .fall      (fall)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: a level is accepted once the raw samples feeding the
  // last D counter cycles all disagree with the current stable level.
  logic [W-1:0] hist [0:8191];
  int           clear_edge = 1 << 24;
  int           last_flip [W];
  logic [W-1:0] m_stable, m_rise, m_fall, m_t, m_c, m_leds;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic tick(input logic [W-1:0] sw, input logic [1:0] md, input logic clr);
    logic [W-1:0] n_stable, n_rise, n_fall, exp_leds;
    logic         ok;
    @(negedge clock);
    switches = sw;
    mode     = md;
    clear    = clr;
    @(posedge clock);
    edge_n++;
    hist[edge_n] = sw;
    if (clr) begin
      m_stable = '0; m_rise = '0; m_fall = '0; m_t = '0; m_c = '0; m_leds = '0;
      clear_edge = edge_n;
      for (int i = 0; i < W; i++) last_flip[i] = edge_n;
    end else begin
      n_stable = m_stable; n_rise = '0; n_fall = '0;
      for (int i = 0; i < W; i++) begin
        ok = (edge_n - S - D + 1 > clear_edge) && (edge_n - D + 1 > last_flip[i]);
        for (int j = 0; j < D; j++) begin
          if (ok && hist[edge_n - S - j][i] == m_stable[i]) ok = 1'b0;
        end
        if (ok) begin
          n_stable[i] = ~m_stable[i];
          n_rise[i]   = ~m_stable[i];
          n_fall[i]   = m_stable[i];
          last_flip[i] = edge_n;
        end
      end
      case (md)
        2'd0: m_leds = m_stable;
        2'd1: m_leds = m_t;
        2'd2: m_leds = m_c;
        default: m_leds = m_leds;
      endcase
      m_t      = m_t ^ n_rise;
      m_c      = m_c + 4'($countones(n_rise));
      m_stable = n_stable;
      m_rise   = n_rise;
      m_fall   = n_fall;
    end
    exp_leds = m_leds;
`ifdef SWITCH_DEBOUNCE_LEDS_HEARTBEAT_EN
    exp_leds[W-1] = (((edge_n - clear_edge) / H) % 2) == 1;
`endif
    #1;
    check("sw_stable", 32'(sw_stable), 32'(m_stable));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("leds", 32'(leds), 32'(exp_leds));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, got, nrise, cnt_exp;
    logic [W-1:0] sw, rs;
    logic [1:0]   md;

    // Reset state
    for (int i = 0; i < 3; i++) tick(4'b0000, 2'd0, 1'b1);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_stable", 32'(sw_stable), 32'h0);
    for (int i = 0; i < 4; i++) tick(4'b0000, 2'd0, 1'b0);

    // Clean edge in pass mode: rise S+D-1 edges after first sample
    k = edge_n + 1; got = -1;
    for (int c = 0; c < 12; c++) begin
      tick(4'b0001, 2'd0, 1'b0);
      if (rise[0] && got < 0) begin
        got = edge_n;
        tick(4'b0001, 2'd0, 1'b0);
        check("clean_leds_next", 32'(leds & LMASK), 32'(4'b0001 & LMASK));
      end
    end
    check("clean_latency", 32'(got), 32'(k + S + D - 1));

    // Bounce on channel 1: single rise, 5 edges after the final low->high
    nrise = 0; got = -1; k = -1;
    for (int c = 0; c < 14; c++) begin
      sw = (c < 3 || c >= 4) ? 4'b0011 : 4'b0001;
      if (c == 4) k = edge_n + 1;
      tick(sw, 2'd0, 1'b0);
      if (rise[1]) begin nrise++; got = edge_n; end
    end
    check("bounce_rise_count", 32'(nrise), 32'd1);
    check("bounce_latency", 32'(got), 32'(k + S + D - 1));

    // Toggle mode on channel 2: press, release, press
    for (int c = 0; c < 10; c++) tick(4'b0111, 2'd1, 1'b0);
    check("toggle_press1", 32'(leds[2]), 32'd1);
    for (int c = 0; c < 10; c++) tick(4'b0011, 2'd1, 1'b0);
    check("toggle_release1", 32'(leds[2]), 32'd1);
    for (int c = 0; c < 10; c++) tick(4'b0111, 2'd1, 1'b0);
    check("toggle_press2", 32'(leds[2]), 32'd0);
    for (int c = 0; c < 10; c++) tick(4'b0011, 2'd1, 1'b0);
    check("toggle_release2", 32'(leds[2]), 32'd0);

    // Count mode: all four switches together, five times, wraps mod 16
    tick(4'b0000, 2'd2, 1'b1);
    for (int p = 1; p <= 5; p++) begin
      for (int c = 0; c < 10; c++) tick(4'b1111, 2'd2, 1'b0);
      cnt_exp = (p * 4) % 16;
      check("count_value", 32'(leds & LMASK), 32'(4'(cnt_exp) & LMASK));
      for (int c = 0; c < 10; c++) tick(4'b0000, 2'd2, 1'b0);
    end

    // Freeze holds 0011 through switch activity, pass mode shows stable next edge
    tick(4'b0000, 2'd0, 1'b1);
    for (int c = 0; c < 10; c++) tick(4'b0011, 2'd0, 1'b0);
    check("freeze_setup", 32'(leds & LMASK), 32'(4'b0011 & LMASK));
    for (int c = 0; c < 20; c++) tick((c < 10) ? 4'b1100 : 4'b0101, 2'd3, 1'b0);
    check("freeze_hold", 32'(leds & LMASK), 32'(4'b0011 & LMASK));
    tick(4'b0101, 2'd0, 1'b0);
    check("unfreeze", 32'(leds & LMASK), 32'(4'b0101 & LMASK));

    // Clear mid-debounce with 1111 held
    for (int c = 0; c < 10; c++) tick(4'b0000, 2'd0, 1'b0);
    tick(4'b1111, 2'd0, 1'b0);
    tick(4'b1111, 2'd0, 1'b0);
    tick(4'b1111, 2'd0, 1'b1);
    check("clear_stable", 32'(sw_stable), 32'h0);
    check("clear_rise", 32'(rise), 32'h0);
    check("clear_leds", 32'(leds), 32'h0);
    got = -1;
    for (int c = 1; c <= 20; c++) begin
      tick(4'b1111, 2'd0, 1'b0);
      if (rise == 4'b1111 && got < 0) got = c;
    end
    check("clear_rise_latency", 32'(got), 32'(S + D));

    // Randomized traffic against the reference model
    sw = 4'b0000; md = 2'd0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 5) == 0) sw[i] = ~sw[i];
      end
      if ($urandom_range(0, 9) == 0) md = 2'($urandom_range(0, 3));
      tick(sw, md, ($urandom_range(0, 199) == 0));
      rs = rise & fall;
      check("rise_fall_exclusive", 32'(rs), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
